// File: rtl/alu_instr_sequencer_if.sv
// Handshake and datapath-strobe bundle between the ALU instruction sequencer and its datapath.
// master = sequencer side, slave = datapath/memory side.
interface alu_instr_sequencer_if #(
   parameter int NUM_REGS = 16,
   parameter int OPCODE_W = 5
);
   // Handshakes: mem_ready and alu_done are level "result valid" flags sampled on the
   // rising clock edge while the sequencer is stalled in T1/T4; there is no ready back-pressure.
   logic                run;
   logic [31:0]         ir;
   logic                mem_ready;
   logic                alu_done;

   logic                PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin;
   logic                Yin, ZLOin, ZHIin, ZLowout, ZHighout, LOin, HIin, Cout;
   logic [OPCODE_W-1:0] alu_op;
   logic [NUM_REGS-1:0] rin_sel;
   logic [NUM_REGS-1:0] rout_sel;
   logic                busy;
   logic                halted;
   logic [1:0]          fault;
   logic [3:0]          state_dbg;

   modport master (
      input  run, ir, mem_ready, alu_done,
      output PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin,
             Yin, ZLOin, ZHIin, ZLowout, ZHighout, LOin, HIin, Cout,
             alu_op, rin_sel, rout_sel, busy, halted, fault, state_dbg
   );

   modport slave (
      output run, ir, mem_ready, alu_done,
      input  PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin,
             Yin, ZLOin, ZHIin, ZLowout, ZHighout, LOin, HIin, Cout,
             alu_op, rin_sel, rout_sel, busy, halted, fault, state_dbg
   );
endinterface

// File: rtl/alu_instr_sequencer.sv
// Moore fetch/decode/execute sequencer for 3-register ALU instructions (mul/div into HI/LO).
// Optional feature macro SEQ_IMM_EN: enables addi/andi/ori, which drive Cout instead of rout_sel[Rc].
module alu_instr_sequencer #(
   parameter int NUM_REGS  = 16,
   parameter int REG_SEL_W = 4,
   parameter int OPCODE_W  = 5,
   parameter int WAIT_MAX  = 15
) (
   input  logic                  clk,
   input  logic                  clr,
   alu_instr_sequencer_if.master bus
);

   localparam int WAIT_W = $clog2(WAIT_MAX + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

   localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(5'b00011);
   localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(5'b00100);
   localparam logic [OPCODE_W-1:0] OP_SHR = OPCODE_W'(5'b00101);
   localparam logic [OPCODE_W-1:0] OP_SHL = OPCODE_W'(5'b00110);
   localparam logic [OPCODE_W-1:0] OP_ROR = OPCODE_W'(5'b00111);
   localparam logic [OPCODE_W-1:0] OP_ROL = OPCODE_W'(5'b01000);
   localparam logic [OPCODE_W-1:0] OP_AND = OPCODE_W'(5'b01001);
   localparam logic [OPCODE_W-1:0] OP_OR  = OPCODE_W'(5'b01010);
   localparam logic [OPCODE_W-1:0] OP_MUL = OPCODE_W'(5'b01110);
   localparam logic [OPCODE_W-1:0] OP_DIV = OPCODE_W'(5'b01111);
   localparam logic [OPCODE_W-1:0] OP_NEG = OPCODE_W'(5'b10000);
   localparam logic [OPCODE_W-1:0] OP_NOT = OPCODE_W'(5'b10001);
`ifdef SEQ_IMM_EN
   localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(5'b11000);
   localparam logic [OPCODE_W-1:0] OP_ANDI = OPCODE_W'(5'b11001);
   localparam logic [OPCODE_W-1:0] OP_ORI  = OPCODE_W'(5'b11010);
`endif

   typedef enum logic [3:0] {
      S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
   } state_t;

   state_t              state;
   logic [WAIT_W-1:0]   wait_cnt;
   logic [1:0]          fault_q;

   logic [OPCODE_W-1:0]  op;
   logic [REG_SEL_W-1:0] ra, rb, rc;
   logic                 op_legal;
   logic                 op_muldiv;
   logic [OPCODE_W-1:0]  alu_sel;
   logic                 unused_ir;

   assign op        = bus.ir[31 -: OPCODE_W];
   assign ra        = bus.ir[31-OPCODE_W -: REG_SEL_W];
   assign rb        = bus.ir[31-OPCODE_W-REG_SEL_W -: REG_SEL_W];
   assign rc        = bus.ir[31-OPCODE_W-2*REG_SEL_W -: REG_SEL_W];
   assign unused_ir = ^bus.ir[31-OPCODE_W-3*REG_SEL_W:0];
   assign op_muldiv = (op == OP_MUL) || (op == OP_DIV);

`ifdef SEQ_IMM_EN
   logic op_imm;
   assign op_imm = (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
`endif

   // Immediate forms reuse the ALU code of their register counterpart.
   always_comb begin
      op_legal = 1'b0;
      alu_sel  = op;
      case (op)
         OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR,
         OP_MUL, OP_DIV, OP_NEG, OP_NOT: op_legal = 1'b1;
`ifdef SEQ_IMM_EN
         OP_ADDI: begin op_legal = 1'b1; alu_sel = OP_ADD; end
         OP_ANDI: begin op_legal = 1'b1; alu_sel = OP_AND; end
         OP_ORI:  begin op_legal = 1'b1; alu_sel = OP_OR;  end
`endif
         default: op_legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state    <= S_IDLE;
         wait_cnt <= '0;
         fault_q  <= 2'b00;
      end else begin
         case (state)
            S_IDLE: if (bus.run) state <= S_T0;
            S_T0: begin
               state    <= S_T1;
               wait_cnt <= '0;
            end
            // A ready arriving on the last allowed stall cycle still completes the fetch.
            S_T1: begin
               if (bus.mem_ready) begin
                  state <= S_T2;
               end else if (wait_cnt == WAIT_LAST) begin
                  state   <= S_HALT;
                  fault_q <= 2'b10;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            S_T2: state <= S_T3;
            S_T3: begin
               if (!op_legal) begin
                  state   <= S_HALT;
                  fault_q <= 2'b01;
               end else begin
                  state    <= S_T4;
                  wait_cnt <= '0;
               end
            end
            S_T4: begin
               if (!op_muldiv || bus.alu_done) begin
                  state <= S_T5;
               end else if (wait_cnt == WAIT_LAST) begin
                  state   <= S_HALT;
                  fault_q <= 2'b11;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            S_T5: begin
               if (op_muldiv)    state <= S_T6;
               else if (bus.run) state <= S_T0;
               else              state <= S_IDLE;
            end
            S_T6:   state <= bus.run ? S_T0 : S_IDLE;
            S_HALT: state <= S_HALT;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Strobes decode from the registered state plus the live IR, so the register selects
   // track whatever IRin loaded during T2.
   always_comb begin
      bus.PCout    = 1'b0;
      bus.MARin    = 1'b0;
      bus.IncPC    = 1'b0;
      bus.PCin     = 1'b0;
      bus.Read     = 1'b0;
      bus.MDRin    = 1'b0;
      bus.MDRout   = 1'b0;
      bus.IRin     = 1'b0;
      bus.Yin      = 1'b0;
      bus.ZLOin    = 1'b0;
      bus.ZHIin    = 1'b0;
      bus.ZLowout  = 1'b0;
      bus.ZHighout = 1'b0;
      bus.LOin     = 1'b0;
      bus.HIin     = 1'b0;
      bus.Cout     = 1'b0;
      bus.alu_op   = '0;
      bus.rin_sel  = '0;
      bus.rout_sel = '0;
      case (state)
         S_T0: begin
            bus.PCout = 1'b1;
            bus.MARin = 1'b1;
            bus.IncPC = 1'b1;
            bus.ZLOin = 1'b1;
         end
         S_T1: begin
            bus.ZLowout = 1'b1;
            bus.PCin    = 1'b1;
            bus.Read    = 1'b1;
            bus.MDRin   = 1'b1;
         end
         S_T2: begin
            bus.MDRout = 1'b1;
            bus.IRin   = 1'b1;
         end
         S_T3: begin
            bus.rout_sel[rb] = 1'b1;
            bus.Yin          = 1'b1;
         end
         S_T4: begin
            bus.ZLOin  = 1'b1;
            bus.ZHIin  = op_muldiv;
            bus.alu_op = alu_sel;
`ifdef SEQ_IMM_EN
            if (op_imm) bus.Cout = 1'b1;
            else        bus.rout_sel[rc] = 1'b1;
`else
            bus.rout_sel[rc] = 1'b1;
`endif
         end
         S_T5: begin
            bus.ZLowout = 1'b1;
            if (op_muldiv) bus.LOin = 1'b1;
            else           bus.rin_sel[ra] = 1'b1;
         end
         S_T6: begin
            bus.ZHighout = 1'b1;
            bus.HIin     = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.busy      = (state != S_IDLE) && (state != S_HALT);
   assign bus.halted    = (state == S_HALT);
   assign bus.fault     = fault_q;
   assign bus.state_dbg = state;

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Self-checking bench for alu_instr_sequencer: an instruction-level model expands each
// randomized instruction into the expected per-cycle strobe pattern, then a driver replays it.
module tb_alu_instr_sequencer;

   localparam int WAIT_MAX = 15;

   localparam logic [15:0] M_PCOUT    = 16'h8000;
   localparam logic [15:0] M_MARIN    = 16'h4000;
   localparam logic [15:0] M_INCPC    = 16'h2000;
   localparam logic [15:0] M_PCIN     = 16'h1000;
   localparam logic [15:0] M_READ     = 16'h0800;
   localparam logic [15:0] M_MDRIN    = 16'h0400;
   localparam logic [15:0] M_MDROUT   = 16'h0200;
   localparam logic [15:0] M_IRIN     = 16'h0100;
   localparam logic [15:0] M_YIN      = 16'h0080;
   localparam logic [15:0] M_ZLOIN    = 16'h0040;
   localparam logic [15:0] M_ZHIIN    = 16'h0020;
   localparam logic [15:0] M_ZLOWOUT  = 16'h0010;
   localparam logic [15:0] M_ZHIGHOUT = 16'h0008;
   localparam logic [15:0] M_LOIN     = 16'h0004;
   localparam logic [15:0] M_HIIN     = 16'h0002;
   localparam logic [15:0] M_COUT     = 16'h0001;

   logic clk = 1'b0;
   logic clr;

   alu_instr_sequencer_if bus ();

   alu_instr_sequencer dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;

   typedef struct packed {
      logic        run;
      logic        mem_ready;
      logic        alu_done;
      logic        clr_mid;
      logic [31:0] ir;
   } stim_t;

   stim_t       stim_q[$];
   logic [63:0] exp_q[$];
   string       tag_q[$];
   logic [31:0] cur_ir;
   bit          idle;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] mk(input logic [15:0] str, input logic [4:0] aop,
                                      input logic [15:0] rin, input logic [15:0] rout,
                                      input logic busy, input logic halted, input logic [1:0] fault);
      return {7'd0, str, aop, rin, rout, busy, halted, fault};
   endfunction

   function automatic logic [63:0] observed();
      return {7'd0, bus.PCout, bus.MARin, bus.IncPC, bus.PCin, bus.Read, bus.MDRin,
              bus.MDRout, bus.IRin, bus.Yin, bus.ZLOin, bus.ZHIin, bus.ZLowout,
              bus.ZHighout, bus.LOin, bus.HIin, bus.Cout, bus.alu_op, bus.rin_sel,
              bus.rout_sel, bus.busy, bus.halted, bus.fault};
   endfunction

   function automatic logic [15:0] onehot(input logic [3:0] r);
      return 16'd1 << r;
   endfunction

   function automatic bit is_imm(input logic [4:0] op);
`ifdef SEQ_IMM_EN
      return op inside {5'b11000, 5'b11001, 5'b11010};
`else
      return (op == 5'b11111) && (op != 5'b11111);
`endif
   endfunction

   function automatic bit is_legal(input logic [4:0] op);
      return (op inside {5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000,
                         5'b01001, 5'b01010, 5'b01110, 5'b01111, 5'b10000, 5'b10001})
             || is_imm(op);
   endfunction

   function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                         input logic [3:0] rb, input logic [3:0] rc);
      return {op, ra, rb, rc, 15'($urandom)};
   endfunction

   function automatic logic rnd();
      return 1'($urandom);
   endfunction

   task automatic push(input string tag, input logic run, input logic mr, input logic ad,
                       input logic clr_mid, input logic [63:0] ex);
      stim_t s;
      s.run       = run;
      s.mem_ready = mr;
      s.alu_done  = ad;
      s.clr_mid   = clr_mid;
      s.ir        = cur_ir;
      stim_q.push_back(s);
      exp_q.push_back(ex);
      tag_q.push_back(tag);
   endtask

   // A halted sequencer stays put with its fault code until clr, which ends the episode.
   task automatic push_halt(input logic [1:0] f);
      for (int i = 0; i < 3; i++) push("HALT", rnd(), rnd(), rnd(), 1'b0, mk(16'h0, 5'd0, 16'h0, 16'h0, 1'b0, 1'b1, f));
      push("HALT_clr", 1'b0, rnd(), rnd(), 1'b1, mk(16'h0, 5'd0, 16'h0, 16'h0, 1'b0, 1'b1, f));
      idle = 1'b1;
   endtask

   // Expand one instruction into its expected cycle-by-cycle outputs.
   task automatic plan_instr(input logic [31:0] ir, input int mem_stalls, input int alu_stalls,
                             input bit run_end, input bit clr_at_t4);
      logic [4:0]  op;
      logic [3:0]  ra, rb, rc;
      bit          md;
      logic [15:0] str4, rout4;
      logic [4:0]  aop4;
      logic [63:0] t1, t4;
      op = ir[31:27];
      ra = ir[26:23];
      rb = ir[22:19];
      rc = ir[18:15];
      md = (op == 5'b01110) || (op == 5'b01111);

      if (idle) push("IDLE_go", 1'b1, rnd(), rnd(), 1'b0, 64'd0);
      idle = 1'b0;
      push("T0", rnd(), rnd(), rnd(), 1'b0,
           mk(M_PCOUT | M_MARIN | M_INCPC | M_ZLOIN, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0, 2'b00));

      t1 = mk(M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0, 2'b00);
      for (int i = 0; i < mem_stalls && i < WAIT_MAX; i++) push("T1_stall", rnd(), 1'b0, rnd(), 1'b0, t1);
      if (mem_stalls >= WAIT_MAX) begin
         push_halt(2'b10);
         return;
      end
      push("T1", rnd(), 1'b1, rnd(), 1'b0, t1);

      cur_ir = ir;
      push("T2", rnd(), rnd(), rnd(), 1'b0, mk(M_MDROUT | M_IRIN, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0, 2'b00));
      push("T3", rnd(), rnd(), rnd(), 1'b0, mk(M_YIN, 5'd0, 16'h0, onehot(rb), 1'b1, 1'b0, 2'b00));
      if (!is_legal(op)) begin
         push_halt(2'b01);
         return;
      end

      str4  = M_ZLOIN | (md ? M_ZHIIN : 16'h0);
      rout4 = onehot(rc);
      aop4  = op;
      if (is_imm(op)) begin
         str4  = str4 | M_COUT;
         rout4 = 16'h0;
         aop4  = (op == 5'b11000) ? 5'b00011 : (op == 5'b11001) ? 5'b01001 : 5'b01010;
      end
      t4 = mk(str4, aop4, 16'h0, rout4, 1'b1, 1'b0, 2'b00);
      if (md) begin
         for (int i = 0; i < alu_stalls && i < WAIT_MAX; i++) push("T4_stall", rnd(), rnd(), 1'b0, 1'b0, t4);
         if (alu_stalls >= WAIT_MAX) begin
            push_halt(2'b11);
            return;
         end
      end
      if (clr_at_t4) begin
         push("T4_clr", 1'b0, rnd(), md ? 1'b1 : rnd(), 1'b1, t4);
         idle = 1'b1;
         return;
      end
      push("T4", rnd(), rnd(), md ? 1'b1 : rnd(), 1'b0, t4);

      if (md) begin
         push("T5", rnd(), rnd(), rnd(), 1'b0, mk(M_ZLOWOUT | M_LOIN, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0, 2'b00));
         push("T6", run_end, rnd(), rnd(), 1'b0, mk(M_ZHIGHOUT | M_HIIN, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0, 2'b00));
      end else begin
         push("T5", run_end, rnd(), rnd(), 1'b0, mk(M_ZLOWOUT, 5'd0, onehot(ra), 16'h0, 1'b1, 1'b0, 2'b00));
      end
      if (!run_end) begin
         push("IDLE_stay", 1'b0, rnd(), rnd(), 1'b0, 64'd0);
         idle = 1'b1;
      end
   endtask

   function automatic int pick_stalls();
      int r;
      r = $urandom_range(0, 9);
      if (r < 6)      return $urandom_range(0, 3);
      else if (r < 9) return $urandom_range(12, 14);
      else            return $urandom_range(15, 16);
   endfunction

   initial begin
      stim_t      st;
      logic [4:0] picks[15];
      logic [4:0] op;

      picks = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001,
                5'b01010, 5'b01110, 5'b01111, 5'b10000, 5'b10001, 5'b11000, 5'b11001, 5'b11010};

      clr           = 1'b1;
      bus.run       = 1'b0;
      bus.mem_ready = 1'b0;
      bus.alu_done  = 1'b0;
      bus.ir        = 32'd0;
      cur_ir        = 32'd0;
      idle          = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset", observed(), 64'd0);
      clr = 1'b0;
      @(posedge clk);
      #1;
      check("reset_idle", observed(), 64'd0);

      plan_instr(32'h4A920000, 0, 0, 1'b1, 1'b0);
      plan_instr(32'h4A920000, 2, 0, 1'b1, 1'b0);
      plan_instr(32'h7A920000, 0, 3, 1'b0, 1'b0);
      plan_instr(mk_ir(5'b00011, 4'd7, 4'd1, 4'd9), 1, 0, 1'b1, 1'b1);
      plan_instr(mk_ir(5'b00100, 4'd3, 4'd6, 4'd8), 14, 0, 1'b1, 1'b0);
      plan_instr(mk_ir(5'b01110, 4'd2, 4'd4, 4'd15), 0, 14, 1'b1, 1'b0);
      plan_instr(mk_ir(5'b10000, 4'd11, 4'd12, 4'd0), 0, 0, 1'b1, 1'b0);
      plan_instr(mk_ir(5'b10001, 4'd0, 4'd15, 4'd3), 0, 0, 1'b0, 1'b0);
      plan_instr(mk_ir(5'b00101, 4'd1, 4'd2, 4'd3), 15, 0, 1'b1, 1'b0);
      plan_instr(mk_ir(5'b01111, 4'd5, 4'd2, 4'd4), 0, 15, 1'b1, 1'b0);
      plan_instr(mk_ir(5'b11111, 4'd5, 4'd2, 4'd4), 0, 0, 1'b1, 1'b0);
      plan_instr(mk_ir(5'b11000, 4'd5, 4'd2, 4'd4), 0, 0, 1'b1, 1'b0);

      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 9) < 8) op = picks[$urandom_range(0, 14)];
         else                          op = 5'($urandom);
         plan_instr(mk_ir(op, 4'($urandom), 4'($urandom), 4'($urandom)),
                    pick_stalls(), pick_stalls(), rnd(), ($urandom_range(0, 11) == 0));
      end

      while (stim_q.size() > 0) begin
         string       tag;
         logic [63:0] ex;
         st  = stim_q.pop_front();
         ex  = exp_q.pop_front();
         tag = tag_q.pop_front();
         bus.run       = st.run;
         bus.mem_ready = st.mem_ready;
         bus.alu_done  = st.alu_done;
         bus.ir        = st.ir;
         #1;
         check(tag, observed(), ex);
         if (st.clr_mid) begin
            clr = 1'b1;
            #1;
            check("clr_async", observed(), 64'd0);
            #1;
            clr = 1'b0;
         end
         @(posedge clk);
         #1;
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
